// File: rtl/psum_drain_collector_pkg.sv
// gnnie_psum_pkg: shared types and helpers for the partial-sum drain collector.
//   - default geometry (PE columns, psum width, node count) and derived widths
//   - drain FSM state encoding
//   - sat_add(): signed saturating add used when colliding sums are merged
package gnnie_psum_pkg;

    localparam int PE_DIM_DEF       = 16;
    localparam int PE_OUT_WIDTH_DEF = 8;
    localparam int NUM_NODES_DEF    = 20;
    localparam int LOG_PE_DIM_DEF   = $clog2(PE_DIM_DEF);
    localparam int TAG_WIDTH_DEF    = $clog2(NUM_NODES_DEF);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } drain_state_e;

    // Signed add of two sign-extended w-bit values, clamped to the w-bit range.
    function automatic int sat_add(input int a, input int b, input int w);
        int s;
        int hi;
        int lo;
        s  = a + b;
        hi = (1 <<< (w - 1)) - 1;
        lo = -(1 <<< (w - 1));
        if (s > hi)      s = hi;
        else if (s < lo) s = lo;
        return s;
    endfunction

endpackage

// File: rtl/psum_drain_collector_if.sv
// psum_drain_collector_if: output-buffer write handshake of the drain collector.
//   ob_valid / ob_ready : valid-ready handshake, transfer on valid & ready
//   ob_data             : partial sum (signed two's complement)
//   ob_col              : source PE column
//   ob_tag              : node tag captured with the entry
// master = collector side, slave = merge PE / output buffer side.
interface psum_drain_collector_if
    import gnnie_psum_pkg::*;
#(
    parameter int DATA_W = PE_OUT_WIDTH_DEF,
    parameter int COL_W  = LOG_PE_DIM_DEF,
    parameter int TAG_W  = TAG_WIDTH_DEF
) ();

    logic              ob_valid;
    logic              ob_ready;
    logic [DATA_W-1:0] ob_data;
    logic [COL_W-1:0]  ob_col;
    logic [TAG_W-1:0]  ob_tag;

    modport master (
        output ob_valid,
        output ob_data,
        output ob_col,
        output ob_tag,
        input  ob_ready
    );

    modport slave (
        input  ob_valid,
        input  ob_data,
        input  ob_col,
        input  ob_tag,
        output ob_ready
    );

endinterface

// File: rtl/psum_drain_collector_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req       : request vector (one bit per lane)
//   ptr       : highest-priority lane this cycle
//   grant     : one-hot grant (zero when nothing requests)
//   grant_idx : index of the granted lane
//   grant_vld : some lane was granted
//   ptr_nxt   : lane after the granted one, for the caller's pointer register
module rr_arbiter #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_vld,
    output logic [IW-1:0] ptr_nxt
);

    always_comb begin
        int idx;
        idx       = 0;
        grant_idx = '0;
        grant_vld = 1'b0;
        // Scan lanes starting at ptr and wrapping; first requester wins.
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!grant_vld && req[idx]) begin
                grant_vld = 1'b1;
                grant_idx = IW'(idx);
            end
        end
        grant   = grant_vld ? (N'(1) << grant_idx) : '0;
        ptr_nxt = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
    end

endmodule

// File: rtl/psum_drain_collector.sv
// psum_drain_collector: captures per-column partial sums from the PE row into
// one holding register per column and drains them, one per handshake, in
// round-robin order toward the merge PE / output buffer.
//
// Ports:
//   clk, reset    : clock, asynchronous active-low reset
//   sum_in_bus    : column i sum at [PE_OUT_WIDTH*i +: PE_OUT_WIDTH]
//   in_vd         : per-column one-cycle valid
//   node_tag      : tag of the node in the row, stored with each lane
//   flush         : drain request (level)
//   ob            : output handshake (psum_drain_collector_if.master)
//   pending       : per-lane holding-register occupancy
//   busy          : |pending | ob_valid
//   flush_done    : one-cycle pulse once everything has drained after flush
//   ovf_err       : sticky collision flag
//
// Build option: PSUM_MERGE_ACC_EN -- when defined, a sum arriving on a lane
// that still holds an entry is saturating-added into it and ovf_err is tied
// low; otherwise the new sum is dropped and ovf_err is set.
module psum_drain_collector
    import gnnie_psum_pkg::*;
#(
    parameter int PE_DIM       = PE_DIM_DEF,
    parameter int PE_OUT_WIDTH = PE_OUT_WIDTH_DEF,
    parameter int NUM_NODES    = NUM_NODES_DEF,
    parameter int LOG_PE_DIM   = $clog2(PE_DIM),
    parameter int TAG_WIDTH    = $clog2(NUM_NODES)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [PE_OUT_WIDTH*PE_DIM-1:0] sum_in_bus,
    input  logic [PE_DIM-1:0]              in_vd,
    input  logic [TAG_WIDTH-1:0]           node_tag,
    input  logic                           flush,
    psum_drain_collector_if.master         ob,
    output logic [PE_DIM-1:0]              pending,
    output logic                           busy,
    output logic                           flush_done,
    output logic                           ovf_err
);

    logic [PE_DIM-1:0][PE_OUT_WIDTH-1:0] lane_in;
    logic [PE_DIM-1:0][PE_OUT_WIDTH-1:0] hold_data;
    logic [PE_DIM-1:0][TAG_WIDTH-1:0]    hold_tag;

    logic [PE_DIM-1:0]     grant;
    logic [PE_DIM-1:0]     granted;
    logic [PE_DIM-1:0]     capture;
    logic [PE_DIM-1:0]     collision;
    logic [LOG_PE_DIM-1:0] grant_idx;
    logic [LOG_PE_DIM-1:0] ptr_nxt;
    logic [LOG_PE_DIM-1:0] rr_ptr;
    logic                  grant_vld;
    logic                  ob_load;

    logic                    ob_valid_q;
    logic [PE_OUT_WIDTH-1:0] ob_data_q;
    logic [LOG_PE_DIM-1:0]   ob_col_q;
    logic [TAG_WIDTH-1:0]    ob_tag_q;

    drain_state_e state, state_nxt;

    // Packed slicing already matches the bus layout (column i at W*i).
    assign lane_in = sum_in_bus;

    // Output register may take a new entry when empty or being consumed.
    assign ob_load = !ob_valid_q || ob.ob_ready;

    rr_arbiter #(
        .N  (PE_DIM),
        .IW (LOG_PE_DIM)
    ) u_arb (
        .req       (pending),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld),
        .ptr_nxt   (ptr_nxt)
    );

    // A lane granted this cycle is vacated at the same edge, so it can
    // accept a new sum without colliding.
    assign granted   = grant & {PE_DIM{ob_load}};
    assign capture   = in_vd & (~pending | granted);
    assign collision = in_vd & pending & ~granted;

`ifdef PSUM_MERGE_ACC_EN
    logic [PE_DIM-1:0][PE_OUT_WIDTH-1:0] merged;

    always_comb begin
        merged = '0;
        for (int i = 0; i < PE_DIM; i++) begin
            merged[i] = PE_OUT_WIDTH'(sat_add(int'($signed(hold_data[i])),
                                              int'($signed(lane_in[i])),
                                              PE_OUT_WIDTH));
        end
    end
`endif

    // ---------------- lane holding registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending   <= '0;
            hold_data <= '0;
            hold_tag  <= '0;
        end else begin
            for (int i = 0; i < PE_DIM; i++) begin
                if (capture[i]) begin
                    hold_data[i] <= lane_in[i];
                    hold_tag[i]  <= node_tag;
                    pending[i]   <= 1'b1;
                end else begin
                    if (granted[i]) pending[i] <= 1'b0;
`ifdef PSUM_MERGE_ACC_EN
                    // Held tag is kept; only the value accumulates.
                    if (collision[i]) hold_data[i] <= merged[i];
`endif
                end
            end
        end
    end

    // ---------------- output register + rr pointer ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ob_valid_q <= 1'b0;
            ob_data_q  <= '0;
            ob_col_q   <= '0;
            ob_tag_q   <= '0;
            rr_ptr     <= '0;
        end else if (ob_load) begin
            ob_valid_q <= grant_vld;
            if (grant_vld) begin
                ob_data_q <= hold_data[grant_idx];
                ob_col_q  <= grant_idx;
                ob_tag_q  <= hold_tag[grant_idx];
                rr_ptr    <= ptr_nxt;
            end
        end
    end

    assign ob.ob_valid = ob_valid_q;
    assign ob.ob_data  = ob_data_q;
    assign ob.ob_col   = ob_col_q;
    assign ob.ob_tag   = ob_tag_q;

    assign busy = (|pending) || ob_valid_q;

    // ---------------- collision flag ----------------
`ifdef PSUM_MERGE_ACC_EN
    assign ovf_err = 1'b0;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          ovf_err <= 1'b0;
        else if (|collision) ovf_err <= 1'b1;
    end
`endif

    // ---------------- drain FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (flush)        state_nxt = S_FLUSH;
                else if (|in_vd)  state_nxt = S_RUN;
            end
            S_RUN: begin
                if (flush)        state_nxt = S_FLUSH;
                else if (!busy)   state_nxt = S_IDLE;
            end
            S_FLUSH: begin
                // Sums arriving during the flush must drain too.
                if (!(|pending) && !ob_valid_q && !(|in_vd))
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign flush_done = (state == S_DONE);

endmodule

// File: tb/tb_psum_drain_collector.sv
module tb_psum_drain_collector;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] c;
        logic [4:0] t;
    } ent_t;

    logic         clk;
    logic         rst_n;
    logic [127:0] sum_in_bus;
    logic [15:0]  in_vd;
    logic [4:0]   node_tag;
    logic         flush;
    logic [15:0]  pending;
    logic         busy;
    logic         flush_done;
    logic         ovf_err;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    ent_t sb[$];

    psum_drain_collector_if #(.DATA_W(8), .COL_W(4), .TAG_W(5)) ob_if ();

    psum_drain_collector dut (
        .clk        (clk),
        .reset      (rst_n),
        .sum_in_bus (sum_in_bus),
        .in_vd      (in_vd),
        .node_tag   (node_tag),
        .flush      (flush),
        .ob         (ob_if),
        .pending    (pending),
        .busy       (busy),
        .flush_done (flush_done),
        .ovf_err    (ovf_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // Monitor: every accepted output is compared with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && ob_if.ob_valid && ob_if.ob_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got d=%h col=%0d tag=%0d, required none",
                         ob_if.ob_data, ob_if.ob_col, ob_if.ob_tag);
            end else begin
                ent_t e;
                e = sb.pop_front();
                if (ob_if.ob_data !== e.d || ob_if.ob_col !== e.c || ob_if.ob_tag !== e.t) begin
                    errors++;
                    $display("FAIL out_entry: got d=%h col=%0d tag=%0d, required d=%h col=%0d tag=%0d",
                             ob_if.ob_data, ob_if.ob_col, ob_if.ob_tag, e.d, e.c, e.t);
                end
            end
        end
        if (rst_n && flush_done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [3:0] c, input logic [4:0] t);
        ent_t e;
        e.d = d; e.c = c; e.t = t;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_vd = '0;
        flush = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Present a set of lanes for exactly one capture edge.
    task automatic pulse(input logic [15:0] vd, input logic [127:0] bus, input logic [4:0] tag);
        in_vd      = vd;
        sum_in_bus = bus;
        node_tag   = tag;
        tick();
        in_vd = '0;
    endtask

    task automatic wait_drain(input string name, input int max);
        int n;
        n = 0;
        while ((sb.size() != 0 || ob_if.ob_valid) && n < max) begin
            tick();
            n++;
        end
        chk(name, 32'(n < max), 32'd1);
    endtask

    task automatic wait_done(input string name, input int max);
        int n;
        n = 0;
        while (!flush_done && n < max) begin
            tick();
            n++;
        end
        chk(name, 32'(n < max), 32'd1);
    endtask

    initial begin
        logic [127:0] bus;
        int vcnt;
        sum_in_bus     = '0;
        node_tag       = '0;
        ob_if.ob_ready = 1'b1;

        // ---- reset values ----
        do_reset();
        chk("rst_ob_valid",   32'(ob_if.ob_valid), 32'd0);
        chk("rst_ob_data",    32'(ob_if.ob_data),  32'd0);
        chk("rst_ob_col",     32'(ob_if.ob_col),   32'd0);
        chk("rst_ob_tag",     32'(ob_if.ob_tag),   32'd0);
        chk("rst_pending",    32'(pending),        32'd0);
        chk("rst_busy",       32'(busy),           32'd0);
        chk("rst_flush_done", 32'(flush_done),     32'd0);
        chk("rst_ovf_err",    32'(ovf_err),        32'd0);

        // ---- single lane, two-cycle latency ----
        bus = '0;
        bus[8*2 +: 8] = 8'h35;
        push(8'h35, 4'd2, 5'd7);
        pulse(16'h0004, bus, 5'd7);
        chk("single_pending", 32'(pending), 32'h0004);
        chk("single_not_yet", 32'(ob_if.ob_valid), 32'd0);
        tick();
        chk("single_valid", 32'(ob_if.ob_valid), 32'd1);
        wait_drain("single_drain", 10);

        // ---- all 16 lanes, one entry per cycle in rr order ----
        do_reset();
        bus = '0;
        for (int i = 0; i < 16; i++) begin
            bus[8*i +: 8] = 8'(i);
            push(8'(i), 4'(i), 5'd3);
        end
        pulse(16'hFFFF, bus, 5'd3);
        chk("all_pending", 32'(pending), 32'hFFFF);
        tick();
        vcnt = 0;
        for (int i = 0; i < 16; i++) begin
            vcnt += int'(ob_if.ob_valid);
            tick();
        end
        chk("all_throughput", 32'(vcnt), 32'd16);
        chk("all_valid_low",  32'(ob_if.ob_valid), 32'd0);
        chk("all_busy_low",   32'(busy), 32'd0);
        chk("all_sb_empty",   32'(sb.size()), 32'd0);

        // ---- backpressure: 3 lanes, ob_ready low for 5 cycles ----
        do_reset();
        ob_if.ob_ready = 1'b0;
        bus = '0;
        bus[8*1 +: 8] = 8'h11;
        bus[8*4 +: 8] = 8'h44;
        bus[8*9 +: 8] = 8'h99;
        push(8'h11, 4'd1, 5'd1);
        push(8'h44, 4'd4, 5'd1);
        push(8'h99, 4'd9, 5'd1);
        pulse(16'h0212, bus, 5'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",   32'(ob_if.ob_valid), 32'd1);
            chk("bp_data",    32'(ob_if.ob_data),  32'h11);
            chk("bp_col",     32'(ob_if.ob_col),   32'd1);
            chk("bp_pending", 32'(pending),        32'h0210);
            tick();
        end
        ob_if.ob_ready = 1'b1;
        wait_drain("bp_drain", 20);

        // ---- collision on lane 5 while output is stalled ----
        do_reset();
        ob_if.ob_ready = 1'b0;
        bus = '0;
        bus[8*0 +: 8] = 8'h01;
        push(8'h01, 4'd0, 5'd2);
        pulse(16'h0001, bus, 5'd2);
        tick();
        bus = '0;
        bus[8*5 +: 8] = 8'h70;
        pulse(16'h0020, bus, 5'd2);
        bus[8*5 +: 8] = 8'h20;
        pulse(16'h0020, bus, 5'd4);
`ifdef PSUM_MERGE_ACC_EN
        push(8'h7F, 4'd5, 5'd2);
        chk("coll_ovf", 32'(ovf_err), 32'd0);
`else
        push(8'h70, 4'd5, 5'd2);
        chk("coll_ovf", 32'(ovf_err), 32'd1);
`endif
        chk("coll_pending", 32'(pending), 32'h0020);
        ob_if.ob_ready = 1'b1;
        wait_drain("coll_drain", 20);
`ifdef PSUM_MERGE_ACC_EN
        chk("coll_ovf_sticky", 32'(ovf_err), 32'd0);
`else
        chk("coll_ovf_sticky", 32'(ovf_err), 32'd1);
`endif

        // ---- flush with nothing buffered ----
        do_reset();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("idle_flush_e1", 32'(flush_done), 32'd0);
        tick();
        chk("idle_flush_e2", 32'(flush_done), 32'd1);
        tick();
        chk("idle_flush_e3", 32'(flush_done), 32'd0);

        // ---- flush with 4 lanes pending ----
        do_reset();
        ob_if.ob_ready = 1'b0;
        bus = '0;
        bus[8*3  +: 8] = 8'h30;
        bus[8*6  +: 8] = 8'h60;
        bus[8*7  +: 8] = 8'h70;
        bus[8*12 +: 8] = 8'hC0;
        push(8'h30, 4'd3,  5'd9);
        push(8'h60, 4'd6,  5'd9);
        push(8'h70, 4'd7,  5'd9);
        push(8'hC0, 4'd12, 5'd9);
        pulse(16'h10C8, bus, 5'd9);
        tick();
        done_cnt = 0;
        flush = 1'b1;
        ob_if.ob_ready = 1'b1;
        tick();
        flush = 1'b0;
        wait_done("flush4_done_seen", 30);
        chk("flush4_drained", 32'(sb.size()), 32'd0);
        chk("flush4_ob_idle", 32'(ob_if.ob_valid), 32'd0);
        tick();
        chk("flush4_pulse_end", 32'(flush_done), 32'd0);
        repeat (5) tick();
        chk("flush4_one_pulse", 32'(done_cnt), 32'd1);

        // ---- in_vd during FLUSH delays flush_done ----
        do_reset();
        ob_if.ob_ready = 1'b0;
        bus = '0;
        bus[8*0 +: 8] = 8'h0A;
        push(8'h0A, 4'd0, 5'd11);
        pulse(16'h0001, bus, 5'd11);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus = '0;
        bus[8*8 +: 8] = 8'h88;
        push(8'h88, 4'd8, 5'd12);
        pulse(16'h0100, bus, 5'd12);
        for (int i = 0; i < 3; i++) begin
            chk("late_no_done", 32'(flush_done), 32'd0);
            tick();
        end
        ob_if.ob_ready = 1'b1;
        wait_done("late_done_seen", 30);
        chk("late_drained", 32'(sb.size()), 32'd0);

        // ---- asynchronous reset mid-drain ----
        do_reset();
        bus = '0;
        for (int i = 0; i < 16; i++) begin
            bus[8*i +: 8] = 8'(8'h80 + i);
            push(8'(8'h80 + i), 4'(i), 5'd5);
        end
        pulse(16'hFFFF, bus, 5'd5);
        repeat (3) tick();
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_valid",   32'(ob_if.ob_valid), 32'd0);
        chk("mid_rst_data",    32'(ob_if.ob_data),  32'd0);
        chk("mid_rst_col",     32'(ob_if.ob_col),   32'd0);
        chk("mid_rst_pending", 32'(pending),        32'd0);
        chk("mid_rst_busy",    32'(busy),           32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus = '0;
        bus[8*2 +: 8] = 8'h22;
        bus[8*7 +: 8] = 8'h77;
        push(8'h22, 4'd2, 5'd6);
        push(8'h77, 4'd7, 5'd6);
        pulse(16'h0084, bus, 5'd6);
        wait_drain("post_rst_drain", 20);

        repeat (3) tick();
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
